// File: rtl/store_write_buffer_pkg.sv
// Shared processor definitions for the store write buffer: byte-enable codes,
// queued-store record layout and the memory-port state encoding.
package store_write_buffer_pkg;

    localparam int SWB_AW = 16;
    localparam int SWB_DW = 16;

    localparam logic [1:0] BE_NONE = 2'b00;
    localparam logic [1:0] BE_LO   = 2'b01;
    localparam logic [1:0] BE_HI   = 2'b10;
    localparam logic [1:0] BE_WORD = 2'b11;

    typedef struct packed {
        logic [SWB_AW-1:0] addr;
        logic [SWB_DW-1:0] data;
        logic [1:0]        be;
    } store_entry_t;

    typedef enum logic {
        SWB_IDLE  = 1'b0,
        SWB_WRITE = 1'b1
    } swb_state_e;

endpackage

// File: rtl/store_write_buffer_if.sv
// Store-side handshake, memory write port and load-hazard signals of the
// store write buffer, bundled with modports for the buffer and its surroundings.
interface store_write_buffer_if #(
    parameter int DEPTH = 4,
    parameter int AW    = 16,
    parameter int DW    = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          st_valid;
    logic          st_ready;
    logic [AW-1:0] st_addr;
    logic [DW-1:0] st_data;
    logic [1:0]    st_be;

    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [1:0]    mem_be;
    logic          mem_ack;

    logic [AW-1:0] ld_addr;
    logic          ld_hit;
    logic          empty;
    logic [CW-1:0] count;

    modport slave (
        input  st_valid, st_addr, st_data, st_be, mem_ack, ld_addr,
        output st_ready, mem_we, mem_addr, mem_wdata, mem_be, ld_hit, empty, count
    );

    modport master (
        output st_valid, st_addr, st_data, st_be, mem_ack, ld_addr,
        input  st_ready, mem_we, mem_addr, mem_wdata, mem_be, ld_hit, empty, count
    );

endinterface

// File: rtl/store_write_buffer_fifo.sv
// Circular store queue: entry storage, read/write pointers, occupancy count
// and the occupancy-masked address compare that drives the load-hazard flag.
module store_write_buffer_fifo
    import store_write_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = SWB_AW,
    parameter int DW    = SWB_DW
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic [AW-1:0]              i_wr_addr,
    input  logic [DW-1:0]              i_wr_data,
    input  logic [1:0]                 i_wr_be,
    input  logic                       i_pop,
    output logic [AW-1:0]              o_rd_addr,
    output logic [DW-1:0]              o_rd_data,
    output logic [1:0]                 o_rd_be,
    output logic [$clog2(DEPTH):0]     o_count,
    input  logic [AW-1:0]              i_ld_addr,
    output logic                       o_ld_hit
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] r_addr [DEPTH];
    logic [DW-1:0] r_data [DEPTH];
    logic [1:0]    r_be   [DEPTH];

    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic [PW-1:0] w_off;
    logic          w_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (i_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry payload is not reset: occupancy (count) alone decides validity.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_addr[r_wr_ptr] <= i_wr_addr;
            r_data[r_wr_ptr] <= i_wr_data;
            r_be[r_wr_ptr]   <= i_wr_be;
        end
    end

    assign o_rd_addr = r_addr[r_rd_ptr];
    assign o_rd_data = r_data[r_rd_ptr];
    assign o_rd_be   = r_be[r_rd_ptr];
    assign o_count   = r_count;

    // A slot is live when its distance from rd_ptr (mod DEPTH) is below count.
    always_comb begin
        w_hit = 1'b0;
        w_off = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_off = PW'(i) - r_rd_ptr;
            if (({1'b0, w_off} < r_count) && (r_addr[i] == i_ld_addr)) begin
                w_hit = 1'b1;
            end
        end
    end

    assign o_ld_hit = w_hit;

endmodule

// File: rtl/store_write_buffer.sv
// Store write buffer top: queues datapath stores and drains them one at a time
// to data memory over a req/ack write port, flagging loads that hit a pending store.
module store_write_buffer
    import store_write_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = SWB_AW,
    parameter int DW    = SWB_DW
) (
    input  logic                  clk,
    input  logic                  rst_n,
    store_write_buffer_if.slave   bus
);
    localparam int CW = $clog2(DEPTH) + 1;

    swb_state_e    r_state;
    swb_state_e    w_state_nxt;

    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_wdata;
    logic [1:0]    r_mem_be;

    logic          w_ready;
    logic          w_push;
    logic          w_pop;
    logic          w_load;
    logic [CW-1:0] w_count;
    logic [AW-1:0] w_rd_addr;
    logic [DW-1:0] w_rd_data;
    logic [1:0]    w_rd_be;
    logic          w_ld_hit;

    // No full bypass: a full buffer refuses a push even while popping.
    assign w_ready = (w_count != CW'(DEPTH));
    assign w_push  = bus.st_valid && w_ready;

    store_write_buffer_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_push    (w_push),
        .i_wr_addr (bus.st_addr),
        .i_wr_data (bus.st_data),
        .i_wr_be   (bus.st_be),
        .i_pop     (w_pop),
        .o_rd_addr (w_rd_addr),
        .o_rd_data (w_rd_data),
        .o_rd_be   (w_rd_be),
        .o_count   (w_count),
        .i_ld_addr (bus.ld_addr),
        .o_ld_hit  (w_ld_hit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= SWB_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_pop       = 1'b0;
        case (r_state)
            SWB_IDLE: begin
                if (w_count != '0) begin
                    w_state_nxt = SWB_WRITE;
                    w_load      = 1'b1;
                end
            end
            SWB_WRITE: begin
                if (bus.mem_ack) begin
                    w_pop       = 1'b1;
                    w_state_nxt = SWB_IDLE;
                end
            end
            default: w_state_nxt = SWB_IDLE;
        endcase
    end

    // Port registers capture the head entry on entry to WRITE and hold until the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_be    <= '0;
        end else if (w_load) begin
            r_mem_addr  <= w_rd_addr;
            r_mem_wdata <= w_rd_data;
            r_mem_be    <= w_rd_be;
        end
    end

    assign bus.st_ready  = w_ready;
    assign bus.mem_we    = (r_state == SWB_WRITE);
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.mem_be    = r_mem_be;
    assign bus.ld_hit    = w_ld_hit;
    assign bus.empty     = (w_count == '0);
    assign bus.count     = w_count;

    a_hold_in_wait: assert property (
        @(posedge clk) disable iff (!rst_n)
        (r_state == SWB_WRITE && !bus.mem_ack) |=>
        (r_state == SWB_WRITE && $stable(r_mem_addr) && $stable(r_mem_wdata) && $stable(r_mem_be))
    );

    a_count_bound: assert property (
        @(posedge clk) disable iff (!rst_n) (w_count <= CW'(DEPTH))
    );

endmodule
